// File: rtl/prio_arbiter8_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : prio_arbiter8_if                                           |
// | Purpose  : Request/grant bundle between the masters and the 8-way     |
// |            arbiter.                                                   |
// |   en        : arbiter enable (master -> arbiter)                      |
// |   mode      : 0 fixed priority, 1 round robin (master -> arbiter)     |
// |   req[7:0]  : request lines, bit i = master i (master -> arbiter)     |
// |   gnt[7:0]  : one-hot grant (arbiter -> master)                       |
// |   gnt_idx   : index of granted master (arbiter -> master)             |
// |   gnt_valid : grant active (arbiter -> master)                        |
// |   timeout   : one-cycle pulse after a forced release                  |
// |   invalid   : combinational (req == 0) & en                           |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
interface prio_arbiter8_if;
  logic       en;
  logic       mode;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic       invalid;

  modport master (
    output en, mode, req,
    input  gnt, gnt_idx, gnt_valid, timeout, invalid
  );

  modport slave (
    input  en, mode, req,
    output gnt, gnt_idx, gnt_valid, timeout, invalid
  );
endinterface
`default_nettype wire

// File: rtl/prio_arbiter8.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : prio_arbiter8                                              |
// | Purpose  : 8-requester bus arbiter, fixed-priority or round-robin,    |
// |            with grant hold and forced release after MAX_HOLD cycles.  |
// | Ports    : clk  - system clock (rising edge)                          |
// |            rst  - synchronous active-high reset                       |
// |            bus  - prio_arbiter8_if.slave (en, mode, req in;           |
// |                   gnt, gnt_idx, gnt_valid, timeout, invalid out)      |
// | Params   : MAX_HOLD - max consecutive grant cycles (1..255)           |
// |            CNT_W    - hold counter width, 2**CNT_W > MAX_HOLD         |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module prio_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  prio_arbiter8_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q,     state_d;
  logic [7:0]       gnt_q,       gnt_d;
  logic [2:0]       gnt_idx_q,   gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q,   timeout_d;
  logic [2:0]       last_q,      last_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic [2:0] fixed_win;
  logic [2:0] rr_win;
  logic [2:0] rr_cand;
  logic       rr_found;
  logic [2:0] winner;
  logic       owner_req;
  logic       hold_expired;

  // Winner selection. Fixed priority: later (higher) set bits override.
  // Round robin: scan last-1, last-2, ..., last (mod 8); k=8 wraps to last.
  always_comb begin
    fixed_win = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.req[i]) fixed_win = 3'(i);
    end

    rr_win   = 3'd0;
    rr_found = 1'b0;
    rr_cand  = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      rr_cand = last_q - 3'(k);
      if (!rr_found && bus.req[rr_cand]) begin
        rr_win   = rr_cand;
        rr_found = 1'b1;
      end
    end

    winner = bus.mode ? rr_win : fixed_win;
  end

  assign owner_req    = bus.req[gnt_idx_q];
  assign hold_expired = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    last_d      = last_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.en && (bus.req != 8'd0)) begin
          state_d     = BUSY;
          gnt_d       = 8'b0000_0001 << winner;
          gnt_idx_d   = winner;
          gnt_valid_d = 1'b1;
          last_d      = winner;
          cnt_d       = '0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Returning to IDLE (rather than re-arbitrating here) gives the
        // mandatory one-cycle bus turnaround after every release.
        if (!owner_req || !bus.en || hold_expired) begin
          state_d     = IDLE;
          gnt_d       = 8'd0;
          gnt_idx_d   = 3'd0;
          gnt_valid_d = 1'b0;
          // Only a pure hold-limit release counts as a timeout.
          timeout_d   = owner_req && bus.en && hold_expired;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 8'd0;
        gnt_idx_d   = 3'd0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 8'd0;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      last_q      <= 3'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.invalid   = (bus.req == 8'd0) & bus.en;

endmodule
`default_nettype wire

// File: doc/prio_arbiter8.md
Name: prio_arbiter8

Overview:
- 8-requester bus arbiter that shares a single resource (shared bus/peripheral) among up to eight masters.
- Winner selection uses 8-to-3 priority encoding.
  - Fixed-priority mode: highest index wins.
  - Round-robin mode: the last winner drops to lowest priority.
- Holds a grant while the owner keeps requesting, and force-releases it after a bounded number of cycles.
- Sits between the requesting masters and the resource's select mux.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may last (legal range 1..255).
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbiter enable; 0 blocks new grants and releases any current grant.
- mode  input  1  0 = fixed priority, 1 = round robin; sampled only when arbitrating in IDLE.
- req  input  8  request lines, bit i = master i.
- gnt  output  8  one-hot grant; all zero when no grant.
- gnt_idx  output  3  index of granted master; 0 when no grant.
- gnt_valid  output  1  1 while a grant is active.
- timeout  output  1  one-cycle pulse on the cycle after a forced release.
- invalid  output  1  combinational: (req == 0) & en.

Behaviour:
- All outputs except invalid are registered.
- Reset (rst=1 at a clock edge), regardless of state:
  - state=IDLE; gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - hold counter=0; last-winner register last=0.
  - Reset has priority over every other event, including mid-grant.
- States: IDLE, BUSY.
- IDLE: gnt_valid=0. At each edge with en=1 and req≠0:
  - Select winner w.
  - Next cycle: gnt=1<<w, gnt_idx=w, gnt_valid=1, last=w, counter=0, state=BUSY.
  - Otherwise remain in IDLE.
- Winner selection:
  - mode=0: highest set bit of req.
  - mode=1: search order (last-1), (last-2), …, (last) modulo 8; the first set bit wins.
  - After reset (last=0) the mode=1 order is 7,6,…,0, identical to fixed priority.
- Latency: req sampled at edge k gives the grant visible in the cycle following edge k (1 cycle).
- BUSY: at each edge, counter increments. Release to IDLE (gnt=0, gnt_valid=0, gnt_idx=0) when any of the following holds:
  - (a) req[gnt_idx]=0 — normal release;
  - (b) en=0 — release, no timeout;
  - (c) counter==MAX_HOLD-1 — forced release; timeout=1 for the next cycle only.
- Release precedence on the same edge: (a) and (b) suppress the timeout pulse; (c) pulses only if the requester is still asserting.
- Requests from other masters during BUSY are ignored (no preemption).
- Every release yields exactly one idle cycle (gnt=0) before any new grant. This cycle is the bus turnaround.
- Grant duration never exceeds MAX_HOLD cycles. With MAX_HOLD=1, every grant lasts one cycle and repeated requests give grant/idle alternation.
- After a forced release:
  - mode=0: the same master may win again if it is still the highest requester.
  - mode=1: it is lowest priority.
- Changes to mode while in BUSY take effect at the next arbitration.
- gnt is always one-hot or zero; gnt_idx always matches gnt.

Test Plan:
1. Reset, en=1, mode=0, req=8'b0010_0100 held → one cycle later gnt=8'b0010_0000, gnt_idx=5, gnt_valid=1; drop req[5] → next cycle gnt=0; following cycle gnt=8'b0000_0100, gnt_idx=2.
2. mode=1, req=8'hFF held continuously, MAX_HOLD=16 → grants in order 7,6,5,…,0,7; each lasts 16 cycles, separated by 1 idle cycle; timeout pulses once per grant.
3. mode=0, req=8'h80 held, MAX_HOLD=4 → gnt_valid high exactly 4 cycles, then timeout=1 plus one idle cycle, then master 7 regranted; pattern repeats.
4. During a grant to master 3, raise req[7] → no change to gnt until master 3 drops req[3]; then idle cycle, then gnt_idx=7.
5. During a grant, drive en=0 → next cycle gnt=0, timeout=0; keep en=0 with req=8'h01 → no grant, invalid=0. Set req=0, en=1 → invalid=1.
6. Assert rst mid-grant in mode=1 after master 5 has won → next cycle all outputs 0; then with req=8'hFF and mode=1, first grant goes to master 7 (last reset to 0).
